// File: rtl/xbox_port_arbiter.sv
// xbox_port_arbiter: shares the single XBOX memory port between the host,
// the TPUM operand fetch engine and the result writeback engine. Requesters
// are served round-robin, and a multi-beat burst keeps the port until its
// last beat. Read data returns after a fixed latency and is tagged back to
// the requester that issued the read.

module xbox_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 1024,
    parameter int RD_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = ID_W + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_ARB,
        ST_OWNED
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   owner_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;

    logic [CW-1:0]     scan_idx;
    logic [ID_W-1:0]   winner;
    logic              winner_found;

    logic              accept;
    logic [ID_W-1:0]   acc_id;
    logic              acc_we;
    logic              acc_last;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic [ID_W-1:0]   issue_id_q;
    logic [RD_LAT-1:0]            pipe_vld_q;
    logic [RD_LAT-1:0][ID_W-1:0]  pipe_id_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        scan_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + CW'(i);
            if (scan_idx >= CW'(NUM_REQ)) begin
                scan_idx = scan_idx - CW'(NUM_REQ);
            end
            if (!winner_found && req_valid[scan_idx]) begin
                winner_found = 1'b1;
                winner       = scan_idx[ID_W-1:0];
            end
        end
    end

    // Grant/ready generation, beat acceptance and next ownership state
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        acc_id    = winner;

        if (state_q == ST_OWNED) begin
            acc_id             = owner_q;
            req_ready[owner_q] = req_valid[owner_q];
        end else if (winner_found) begin
            req_ready[winner] = 1'b1;
        end

        accept    = |(req_ready & req_valid);
        acc_we    = req_we[acc_id];
        acc_last  = req_last[acc_id];
        acc_addr  = req_addr[int'(acc_id)*ADDR_W +: ADDR_W];
        acc_wdata = req_wdata[int'(acc_id)*DATA_W +: DATA_W];

        if (accept) begin
            if (acc_last) begin
                // Burst done: hand the port back and move the pointer past the owner
                state_d  = ST_ARB;
                rr_ptr_d = (acc_id == LAST_ID) ? '0 : acc_id + 1'b1;
            end else begin
                state_d = ST_OWNED;
                owner_d = acc_id;
            end
        end
    end

    // Ownership state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Registered memory strobes; address/data hold their last value when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            issue_id_q <= '0;
        end else begin
            mem_rd <= accept & ~acc_we;
            mem_wr <= accept & acc_we;
            if (accept) begin
                mem_addr   <= acc_addr;
                mem_wdata  <= acc_wdata;
                issue_id_q <= acc_id;
            end
        end
    end

    // Read tag pipeline: tracks which requester owns each read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q[0] <= mem_rd;
            pipe_id_q[0]  <= issue_id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
            end
        end
    end

    // Steer the returning read to its issuer as a one-hot valid
    always_comb begin
        rsp_valid = '0;
        if (pipe_vld_q[RD_LAT-1]) begin
            rsp_valid[pipe_id_q[RD_LAT-1]] = 1'b1;
        end
    end

    assign rsp_rdata = mem_rdata;
    assign busy      = (state_q == ST_OWNED) | (|pipe_vld_q) | mem_rd | mem_wr;

endmodule

// File: tb/tb_xbox_port_arbiter.sv
// tb_xbox_port_arbiter: drives per-requester beat queues into the arbiter,
// predicts grants, memory strobes and read returns from a behavioural model,
// and checks DUT outputs against a scoreboard from a separate monitor.

module tb_xbox_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 1024;
    localparam int RD_LAT  = 2;

    typedef struct {
        logic              we;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } beat_t;

    typedef struct {
        int                due;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    beat_t  reqq [NUM_REQ][$];
    issue_t issue_q[$];
    rsp_t   rsp_q[$];

    bit started  [NUM_REQ];
    int gap_left [NUM_REQ];

    int m_owner   = -1;
    int m_ptr     = 0;
    int last_acc  = -100;
    int last_rd   = -100;

    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] xmem [int];
    logic [DATA_W-1:0] rd_line [RD_LAT];

    issue_t             mon_it;
    rsp_t               mon_rs;
    logic [NUM_REQ-1:0] mon_exp;

    xbox_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Free-running clock and cycle index
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] row_default(int a);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W/32; k++) begin
            r[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ 32'(k * 32'h01010101) ^ 32'h5A5A0000;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rand_row();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W/32; k++) begin
            r[k*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return row_default(a);
    endfunction

    // XBOX macro model: writes land at the edge, reads return after RD_LAT cycles
    always @(posedge clk) begin
        for (int k = RD_LAT-1; k > 0; k--) begin
            rd_line[k] = rd_line[k-1];
        end
        if (mem_rd) begin
            rd_line[0] = xmem.exists(int'(mem_addr)) ? xmem[int'(mem_addr)] : row_default(int'(mem_addr));
        end else begin
            rd_line[0] = '0;
        end
        if (mem_wr) begin
            xmem[int'(mem_addr)] = mem_wdata;
        end
    end

    assign mem_rdata = rd_line[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h (low 128 bits)",
                     name, cyc, act[127:0], exp[127:0]);
        end
    endtask

    task automatic loadBeat(input int id, input logic we, input logic last,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata, input int gap);
        beat_t b;
        b.we = we; b.last = last; b.addr = addr; b.wdata = wdata; b.gap = gap;
        reqq[id].push_back(b);
    endtask

    // Behavioural arbiter: decides who should be ready and records expectations
    task automatic modelStep();
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_busy;
        int                 w;
        beat_t              b;
        issue_t             it;
        rsp_t               rs;
        exp_ready = '0;
        w = -1;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) begin
                w = m_owner;
                exp_ready[m_owner] = 1'b1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (w < 0 && req_valid[j]) begin
                    w = j;
                    exp_ready[j] = 1'b1;
                end
            end
        end
        checkOutput("req_ready", req_ready, exp_ready);
        exp_busy = (m_owner >= 0) || (last_acc == cyc - 1) || (last_rd >= cyc - 1 - RD_LAT);
        checkOutput("busy", busy, exp_busy);

        if (w >= 0) begin
            b = reqq[w].pop_front();
            started[w] = 1'b0;
            it.due = cyc + 1; it.rd = ~b.we; it.wr = b.we; it.addr = b.addr; it.wdata = b.wdata;
            issue_q.push_back(it);
            if (b.we) begin
                ref_mem[int'(b.addr)] = b.wdata;
            end else begin
                rs.due = cyc + 1 + RD_LAT; rs.id = w; rs.data = ref_read(int'(b.addr));
                rsp_q.push_back(rs);
                last_rd = cyc;
            end
            last_acc = cyc;
            if (b.last) begin
                m_owner = -1;
                m_ptr   = (w + 1) % NUM_REQ;
            end else begin
                m_owner = w;
            end
        end
    endtask

    // One cycle: present queue heads (honouring gaps), then run the model
    task automatic applyStimulus();
        beat_t b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = 1'b0;
            if (reqq[i].size() > 0) begin
                if (!started[i]) begin
                    started[i]  = 1'b1;
                    gap_left[i] = reqq[i][0].gap;
                end
                if (gap_left[i] > 0) begin
                    gap_left[i]--;
                end else begin
                    b = reqq[i][0];
                    req_valid[i] = 1'b1;
                    req_we[i]    = b.we;
                    req_last[i]  = b.last;
                    req_addr[i*ADDR_W +: ADDR_W]  = b.addr;
                    req_wdata[i*DATA_W +: DATA_W] = b.wdata;
                end
            end
        end
        @(negedge clk);
        modelStep();
    endtask

    function automatic bit reqs_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqq[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic flushAll();
        for (int i = 0; i < NUM_REQ; i++) begin
            reqq[i].delete();
            started[i] = 1'b0;
        end
        issue_q.delete();
        rsp_q.delete();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        while (!(reqs_empty() && issue_q.size() == 0 && rsp_q.size() == 0)) begin
            if (n >= budget) begin
                nvec++;
                nerr++;
                $display("[TB] FAIL drain_timeout: got %0d cycles without going idle, required at most %0d", n, budget);
                flushAll();
                return;
            end
            applyStimulus();
            n++;
        end
        applyStimulus();
    endtask

    task automatic runUntilFed(input int budget);
        int n;
        n = 0;
        while (!reqs_empty()) begin
            if (n >= budget) begin
                nvec++;
                nerr++;
                $display("[TB] FAIL feed_timeout: got %0d cycles with beats pending, required at most %0d", n, budget);
                flushAll();
                return;
            end
            applyStimulus();
            n++;
        end
    endtask

    // Asynchronous reset pulse mid-cycle; checks outputs clear immediately
    task automatic pulseReset();
        @(posedge clk);
        #3;
        req_valid = '0;
        rst_n = 1'b0;
        flushAll();
        m_owner = -1; m_ptr = 0; last_acc = -100; last_rd = -100;
        #1;
        checkOutput("rst_mem_rd", mem_rd, 1'b0);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, '0);
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        checkOutput("rst_rsp_valid", rsp_valid, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_req_ready", req_ready, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares strobes and read returns against the scoreboard
    always @(negedge clk) begin
        if (issue_q.size() > 0 && issue_q[0].due == cyc) begin
            mon_it = issue_q.pop_front();
            checkOutput("mem_rd", mem_rd, mon_it.rd);
            checkOutput("mem_wr", mem_wr, mon_it.wr);
            checkOutput("mem_addr", mem_addr, mon_it.addr);
            if (mon_it.wr) checkOutput("mem_wdata", mem_wdata, mon_it.wdata);
        end else begin
            checkOutput("strobes_idle", {mem_rd, mem_wr}, 2'b00);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            mon_rs  = rsp_q.pop_front();
            mon_exp = '0;
            mon_exp[mon_rs.id] = 1'b1;
            checkOutput("rsp_valid", rsp_valid, mon_exp);
            checkOutput("rsp_rdata", rsp_rdata, mon_rs.data);
        end else begin
            checkOutput("rsp_idle", rsp_valid, '0);
        end
    end

    initial begin
        int nb;
        int len;
        logic we;
        int base;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            started[i]  = 1'b0;
            gap_left[i] = 0;
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        $display("[TB] single read from host");
        loadBeat(0, 1'b0, 1'b1, 14'h0010, '0, 0);
        runUntilIdle(100);

        $display("[TB] fetch write burst with host and writeback waiting");
        for (int k = 0; k < 4; k++) begin
            loadBeat(1, 1'b1, (k == 3), ADDR_W'(14'h0100 + k), rand_row(), 0);
        end
        loadBeat(0, 1'b0, 1'b1, 14'h0020, '0, 0);
        loadBeat(2, 1'b0, 1'b1, 14'h0101, '0, 0);
        runUntilIdle(100);

        $display("[TB] writeback burst with stalled owner");
        loadBeat(2, 1'b0, 1'b0, 14'h0200, '0, 0);
        loadBeat(2, 1'b0, 1'b0, 14'h0201, '0, 5);
        loadBeat(2, 1'b0, 1'b1, 14'h0102, '0, 0);
        loadBeat(0, 1'b0, 1'b1, 14'h0030, '0, 0);
        runUntilIdle(100);

        $display("[TB] round-robin from reset");
        pulseReset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                loadBeat(i, 1'b0, 1'b1, ADDR_W'(14'h0040 + r*NUM_REQ + i), '0, 0);
            end
        end
        runUntilIdle(100);

        $display("[TB] reset with reads in flight");
        loadBeat(0, 1'b0, 1'b1, 14'h0050, '0, 0);
        loadBeat(1, 1'b0, 1'b1, 14'h0051, '0, 0);
        runUntilFed(50);
        pulseReset();
        repeat (6) applyStimulus();
        loadBeat(0, 1'b0, 1'b1, 14'h0052, '0, 0);
        runUntilIdle(100);

        $display("[TB] randomized traffic");
        repeat (30) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                nb = $urandom_range(0, 3);
                for (int bu = 0; bu < nb; bu++) begin
                    len  = $urandom_range(1, 4);
                    we   = 1'($urandom_range(0, 1));
                    base = $urandom_range(0, 15);
                    for (int k = 0; k < len; k++) begin
                        loadBeat(i, we, (k == len - 1), ADDR_W'(base + k), rand_row(),
                                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                    end
                end
            end
            runUntilIdle(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
